// File: rtl/bp_cfg_boot_sequencer.sv
// Boot-time configuration sequencer: walks every core tile, freezes it,
// programs hart id and CCE mode, waits for all acks, then unfreezes each
// core and reports done. Outstanding config writes are bounded by credits.
//
// Handshake: a config write transfers on a cycle where cfg_v_o && cfg_ready_i
// are both high at the rising clock edge. While cfg_v_o is high and
// cfg_ready_i is low, cfg_v_o stays high and core id / address / data hold
// their values. cfg_resp_v_i is a one-cycle ack that is always accepted.
module bp_cfg_boot_sequencer #(
    parameter int num_core_p       = 1,
    parameter int cfg_addr_width_p = 20,
    parameter int cfg_data_width_p = 64,
    parameter int max_credits_p    = 4,
    parameter int cce_mode_p       = 0,
    localparam int core_id_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         start_i,
    output logic                         cfg_v_o,
    input  logic                         cfg_ready_i,
    output logic [core_id_width_lp-1:0]  cfg_core_id_o,
    output logic [cfg_addr_width_p-1:0]  cfg_addr_o,
    output logic [cfg_data_width_p-1:0]  cfg_data_o,
    input  logic                         cfg_resp_v_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [2:0]                   dbg_state_o
);

    localparam int AW  = cfg_addr_width_p;
    localparam int DW  = cfg_data_width_p;
    localparam int CIW = core_id_width_lp;
    localparam int CRW = $clog2(max_credits_p + 1);

    localparam logic [AW-1:0]  ADDR_FREEZE   = AW'(20'h00002);
    localparam logic [AW-1:0]  ADDR_HARTID   = AW'(20'h00004);
    localparam logic [AW-1:0]  ADDR_CCE_MODE = AW'(20'h00006);
    localparam logic [CRW-1:0] CREDITS_MAX   = CRW'(max_credits_p);
    localparam logic [CRW-1:0] CREDIT_ONE    = CRW'(1);
    localparam logic [CIW-1:0] CORE_LAST     = CIW'(num_core_p - 1);
    localparam logic [CIW-1:0] CORE_ONE      = CIW'(1);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_CFG         = 3'd1,
        ST_DRAIN       = 3'd2,
        ST_RELEASE     = 3'd3,
        ST_FINAL_DRAIN = 3'd4,
        ST_DONE        = 3'd5
    } state_e;

    state_e         r_state;
    state_e         w_state_n;
    logic [CIW-1:0] r_core;
    logic [CIW-1:0] w_core_n;
    logic [1:0]     r_step;
    logic [1:0]     w_step_n;
    logic [CRW-1:0] r_credits;

    logic w_write_state;
    logic w_send;
    logic w_resp;
    logic w_credits_full;
    logic w_last_core;

    // Acks seen in IDLE belong to a sequence that was cut short by reset.
    assign w_write_state  = (r_state == ST_CFG) || (r_state == ST_RELEASE);
    assign cfg_v_o        = w_write_state && (r_credits != '0);
    assign w_send         = cfg_v_o && cfg_ready_i;
    assign w_resp         = cfg_resp_v_i && (r_state != ST_IDLE);
    assign w_credits_full = (r_credits == CREDITS_MAX);
    assign w_last_core    = (r_core == CORE_LAST);

    assign busy_o      = (r_state == ST_CFG) || (r_state == ST_DRAIN) ||
                         (r_state == ST_RELEASE) || (r_state == ST_FINAL_DRAIN);
    assign done_o      = (r_state == ST_DONE);
    assign dbg_state_o = r_state;

    // State, core index and step registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
            r_core  <= '0;
            r_step  <= '0;
        end else begin
            r_state <= w_state_n;
            r_core  <= w_core_n;
            r_step  <= w_step_n;
        end
    end

    // Next state: walk core/step on each accepted write, drain credits between phases.
    always_comb begin
        w_state_n = r_state;
        w_core_n  = r_core;
        w_step_n  = r_step;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_n = ST_CFG;
                    w_core_n  = '0;
                    w_step_n  = '0;
                end
            end
            ST_CFG: begin
                if (w_send) begin
                    if (r_step == 2'd2) begin
                        w_step_n = '0;
                        if (w_last_core) begin
                            w_state_n = ST_DRAIN;
                            w_core_n  = '0;
                        end else begin
                            w_core_n = r_core + CORE_ONE;
                        end
                    end else begin
                        w_step_n = r_step + 2'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_credits_full) begin
                    w_state_n = ST_RELEASE;
                    w_core_n  = '0;
                end
            end
            ST_RELEASE: begin
                if (w_send) begin
                    if (w_last_core) begin
                        w_state_n = ST_FINAL_DRAIN;
                        w_core_n  = '0;
                    end else begin
                        w_core_n = r_core + CORE_ONE;
                    end
                end
            end
            ST_FINAL_DRAIN: begin
                if (w_credits_full) w_state_n = ST_DONE;
            end
            ST_DONE: begin
                w_state_n = ST_DONE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    // Write payload decoded from registered state; zero whenever no write is offered.
    always_comb begin
        cfg_core_id_o = '0;
        cfg_addr_o    = '0;
        cfg_data_o    = '0;
        if (cfg_v_o) begin
            cfg_core_id_o = r_core;
            if (r_state == ST_RELEASE) begin
                cfg_addr_o = ADDR_FREEZE;
                cfg_data_o = '0;
            end else begin
                case (r_step)
                    2'd0: begin
                        cfg_addr_o = ADDR_FREEZE;
                        cfg_data_o = DW'(1);
                    end
                    2'd1: begin
                        cfg_addr_o = ADDR_HARTID;
                        cfg_data_o = DW'(r_core);
                    end
                    default: begin
                        cfg_addr_o = ADDR_CCE_MODE;
                        cfg_data_o = DW'(cce_mode_p);
                    end
                endcase
            end
        end
    end

    // Credit counter: send consumes, ack returns; a surplus ack saturates at max.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_credits <= CREDITS_MAX;
        end else if (w_send && !w_resp) begin
            r_credits <= r_credits - CREDIT_ONE;
        end else if (w_resp && !w_send && !w_credits_full) begin
            r_credits <= r_credits + CREDIT_ONE;
        end
    end

    a_resp_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(w_resp && w_credits_full));

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Testbench for bp_cfg_boot_sequencer: a single-core instance and a
// four-core / two-credit instance, each with a cycle-level link model that
// accepts writes, returns acks after a set latency and logs every write.
module tb_bp_cfg_boot_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        start [2];
    logic        ready [2];
    logic        resp  [2];
    logic        v     [2];
    logic        busy  [2];
    logic        done  [2];
    logic [19:0] addr  [2];
    logic [63:0] data  [2];
    logic [2:0]  st    [2];
    logic [0:0]  core0;
    logic [1:0]  core1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CFG   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd5;

    bp_cfg_boot_sequencer #(
        .num_core_p(1), .cfg_addr_width_p(20), .cfg_data_width_p(64),
        .max_credits_p(4), .cce_mode_p(0)
    ) u_dut0 (
        .clk_i(clk), .reset_n_i(rst_n[0]), .start_i(start[0]),
        .cfg_v_o(v[0]), .cfg_ready_i(ready[0]), .cfg_core_id_o(core0),
        .cfg_addr_o(addr[0]), .cfg_data_o(data[0]), .cfg_resp_v_i(resp[0]),
        .busy_o(busy[0]), .done_o(done[0]), .dbg_state_o(st[0])
    );

    bp_cfg_boot_sequencer #(
        .num_core_p(4), .cfg_addr_width_p(20), .cfg_data_width_p(64),
        .max_credits_p(2), .cce_mode_p(1)
    ) u_dut1 (
        .clk_i(clk), .reset_n_i(rst_n[1]), .start_i(start[1]),
        .cfg_v_o(v[1]), .cfg_ready_i(ready[1]), .cfg_core_id_o(core1),
        .cfg_addr_o(addr[1]), .cfg_data_o(data[1]), .cfg_resp_v_i(resp[1]),
        .busy_o(busy[1]), .done_o(done[1]), .dbg_state_o(st[1])
    );

    // ---------------- link model state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc [2];
    int          lat [2];
    int          rdy_mode [2];
    int          outst [2];
    int          max_c [2];
    int          nstall [2];
    int          tgt [2][128];
    int          tgt_rd [2];
    int          tgt_wr [2];
    logic [19:0] log_addr [2][64];
    logic [63:0] log_data [2][64];
    int          log_core [2][64];
    int          log_cyc [2][64];
    int          log_n [2];
    int          resp_cyc [2][64];
    int          resp_n [2];
    logic        start_req [2];
    int          start_cyc [2];
    int          done_cyc [2];
    logic        prev_stall [2];
    logic [19:0] prev_a [2];
    logic [63:0] prev_d [2];
    int          prev_c [2];
    logic [91:0] exp_q [$];

    // ---------------- scoreboard ----------------
    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One negedge of the link model: decides ready/ack/start for the coming edge.
    task automatic mon(input int g, input logic vv, input logic [19:0] a, input logic [63:0] d,
                       input int c, input logic dn, output logic rdy, output logic rsp,
                       output logic stv);
        cyc[g]++;
        stv = start_req[g];
        if (start_req[g]) begin
            start_cyc[g] = cyc[g];
            start_req[g] = 1'b0;
        end
        rdy = (rdy_mode[g] == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (prev_stall[g]) begin
            check_val("hold_v", vv, 1);
            check_val("hold_addr", a, prev_a[g]);
            check_val("hold_data", d, prev_d[g]);
            check_val("hold_core", c, prev_c[g]);
        end
        if (vv) check_val("credit_bound", outst[g] < max_c[g], 1);
        if (dn && done_cyc[g] < 0) done_cyc[g] = cyc[g];
        rsp = 1'b0;
        if (tgt_rd[g] != tgt_wr[g] && tgt[g][tgt_rd[g] % 128] == cyc[g]) begin
            rsp = 1'b1;
            tgt_rd[g]++;
            if (outst[g] > 0) outst[g]--;
            if (resp_n[g] < 64) resp_cyc[g][resp_n[g]] = cyc[g];
            resp_n[g]++;
        end
        if (vv && rdy) begin
            if (log_n[g] < 64) begin
                log_addr[g][log_n[g]] = a;
                log_data[g][log_n[g]] = d;
                log_core[g][log_n[g]] = c;
                log_cyc[g][log_n[g]]  = cyc[g];
            end
            log_n[g]++;
            tgt[g][tgt_wr[g] % 128] = cyc[g] + lat[g];
            tgt_wr[g]++;
            outst[g]++;
        end
        if (vv && !rdy) nstall[g]++;
        prev_stall[g] = vv && !rdy;
        prev_a[g] = a;
        prev_d[g] = d;
        prev_c[g] = c;
    endtask

    logic r0, s0, t0, r1, s1, t1;
    initial forever begin
        @(negedge clk);
        mon(0, v[0], addr[0], data[0], int'(core0), done[0], r0, s0, t0);
        ready[0] = r0; resp[0] = s0; start[0] = t0;
    end
    initial forever begin
        @(negedge clk);
        mon(1, v[1], addr[1], data[1], int'(core1), done[1], r1, s1, t1);
        ready[1] = r1; resp[1] = s1; start[1] = t1;
    end

    // ---------------- driver tasks ----------------
    task automatic clear_run(input int g);
        log_n[g] = 0; resp_n[g] = 0; done_cyc[g] = -1; outst[g] = 0;
        prev_stall[g] = 1'b0; nstall[g] = 0;
    endtask

    task automatic do_reset(input int g);
        @(posedge clk); #2;
        rst_n[g] = 1'b0;
        clear_run(g);
        @(posedge clk); @(posedge clk); #2;
        rst_n[g] = 1'b1;
    endtask

    task automatic start_seq(input int g);
        @(posedge clk); #2;
        start_req[g] = 1'b1;
    endtask

    task automatic wait_done(input int g, input int budget, input string tag);
        int k = 0;
        while (done_cyc[g] < 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, done_cyc[g] >= 0, 1);
    endtask

    // Poll (1 ns steps) until the link model has logged n writes, bounded.
    task automatic wait_log(input int g, input int n, input int budget_ns, input string tag);
        int k = 0;
        while (log_n[g] < n && k < budget_ns) begin
            #1;
            k++;
        end
        check_val(tag, log_n[g] >= n, 1);
    endtask

    task automatic check_seq(input int g, input int nc, input int cm, input string tag);
        logic [19:0] ea;
        logic [63:0] ed;
        logic [91:0] e;
        int ec;
        exp_q.delete();
        for (int k = 0; k < 4 * nc; k++) begin
            if (k < 3 * nc) begin
                ec = k / 3;
                case (k % 3)
                    0:       begin ea = 20'h2; ed = 64'd1; end
                    1:       begin ea = 20'h4; ed = 64'(ec); end
                    default: begin ea = 20'h6; ed = 64'(cm); end
                endcase
            end else begin
                ec = k - 3 * nc;
                ea = 20'h2;
                ed = 64'd0;
            end
            exp_q.push_back({ea, ed, 8'(ec)});
        end
        check_val({tag, "_n_writes"}, log_n[g], 4 * nc);
        for (int k = 0; k < log_n[g] && k < 64 && exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            check_val($sformatf("%s_wr%0d_addr", tag, k), log_addr[g][k], e[91:72]);
            check_val($sformatf("%s_wr%0d_data", tag, k), log_data[g][k], e[71:8]);
            check_val($sformatf("%s_wr%0d_core", tag, k), log_core[g][k], e[7:0]);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- tests ----------------
    initial begin
        for (int g = 0; g < 2; g++) begin
            rst_n[g] = 1'b0; start[g] = 1'b0; ready[g] = 1'b0; resp[g] = 1'b0;
            cyc[g] = 0; lat[g] = 2; rdy_mode[g] = 0; tgt_rd[g] = 0; tgt_wr[g] = 0;
            start_req[g] = 1'b0; start_cyc[g] = 0;
            clear_run(g);
        end
        max_c[0] = 4;
        max_c[1] = 2;
        repeat (3) @(negedge clk);
        check_val("rst0_v", v[0], 0);
        check_val("rst0_busy", busy[0], 0);
        check_val("rst0_done", done[0], 0);
        check_val("rst0_addr", addr[0], 0);
        check_val("rst0_data", data[0], 0);
        check_val("rst0_core", core0, 0);
        check_val("rst1_v", v[1], 0);
        check_val("rst1_busy", busy[1], 0);
        check_val("rst1_done", done[1], 0);
        check_val("rst1_state", st[1], S_IDLE);
        @(posedge clk); #2;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        repeat (2) @(negedge clk);

        // T1: single core, ready high, ack two cycles after each write.
        lat[0] = 2;
        clear_run(0);
        start_seq(0);
        wait_done(0, 60, "t1_done_seen");
        check_seq(0, 1, 0, "t1");
        check_val("t1_first_latency", log_cyc[0][0] - start_cyc[0], 1);
        check_val("t1_release_cycle", log_cyc[0][3] - start_cyc[0], 7);
        check_val("t1_done_cycle", done_cyc[0] - start_cyc[0], 11);
        check_val("t1_done_after_4th_ack", done_cyc[0] > resp_cyc[0][3], 1);
        check_val("t1_busy_after_done", busy[0], 0);

        // T6a: start after done is ignored.
        start_seq(0);
        repeat (6) @(negedge clk);
        check_val("t6_no_new_writes", log_n[0], 4);
        check_val("t6_done_sticky", done[0], 1);
        check_val("t6_state_done", st[0], S_DONE);

        // T2 + T6b: four cores, two credits, ack latency 5; start pulsed in DRAIN.
        lat[1] = 5;
        rdy_mode[1] = 0;
        clear_run(1);
        start_seq(1);
        begin
            int k = 0;
            while (st[1] != S_DRAIN && k < 300) begin
                @(negedge clk);
                k++;
            end
            check_val("t6_saw_drain", st[1], S_DRAIN);
        end
        start_req[1] = 1'b1;
        wait_done(1, 400, "t2_done_seen");
        check_seq(1, 4, 1, "t2");
        check_val("t2_release_after_12th_ack", log_cyc[1][12] > resp_cyc[1][11], 1);
        check_val("t2_done_sticky", done[1], 1);

        // T3: random ready stalls; payload must hold and order must be exact.
        do_reset(1);
        lat[1] = 3;
        rdy_mode[1] = 1;
        start_seq(1);
        wait_done(1, 800, "t3_done_seen");
        check_seq(1, 4, 1, "t3");
        check_val("t3_stalls_seen", nstall[1] > 0, 1);
        rdy_mode[1] = 0;

        // T4: ack latency 1 with two credits -> send+ack each cycle, no bubble.
        do_reset(1);
        lat[1] = 1;
        start_seq(1);
        wait_log(1, 6, 2000, "t4_reached_6_writes");
        check_val("t4_credits_steady", u_dut1.r_credits, 1);
        wait_done(1, 200, "t4_done_seen");
        check_seq(1, 4, 1, "t4");
        check_val("t4_cfg_no_bubble", log_cyc[1][11] - log_cyc[1][0], 11);
        check_val("t4_release_no_bubble", log_cyc[1][15] - log_cyc[1][12], 3);

        // T5: reset at core 2 step 1 with acks in flight, late acks in IDLE, restart.
        do_reset(1);
        lat[1] = 4;
        start_seq(1);
        wait_log(1, 7, 3000, "t5_reached_core2");
        @(posedge clk); #2;
        check_val("t5_state_cfg", st[1], S_CFG);
        check_val("t5_acks_pending", tgt_rd[1] != tgt_wr[1], 1);
        rst_n[1] = 1'b0;
        clear_run(1);
        #1;
        check_val("t5_reset_v", v[1], 0);
        check_val("t5_reset_busy", busy[1], 0);
        @(posedge clk); @(posedge clk); #2;
        rst_n[1] = 1'b1;
        begin
            int k = 0;
            while (tgt_rd[1] != tgt_wr[1] && k < 50) begin
                @(negedge clk);
                k++;
            end
            check_val("t5_late_acks_drained", tgt_rd[1] == tgt_wr[1], 1);
        end
        repeat (2) @(negedge clk);
        check_val("t5_credits_max", u_dut1.r_credits, 2);
        check_val("t5_state_idle", st[1], S_IDLE);
        clear_run(1);
        start_seq(1);
        wait_done(1, 400, "t5_done_seen");
        check_seq(1, 4, 1, "t5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
